// File: rtl/ita_sync_fifo_pkg.sv
// Shared ITA types for the output-row buffer between the FIFO controller and the output controller.
// The generic FIFO does not import this package; integrators size the FIFO from these constants.
package ita_package;

    localparam int unsigned N         = 16;
    localparam int unsigned WI        = 8;
    localparam int unsigned FifoDepth = 4;

    typedef logic [N*WI-1:0]               fifo_data_t;
    typedef logic [$clog2(FifoDepth)-1:0]  fifo_usage_t;

endpackage

// File: rtl/ita_sync_fifo_if.sv
// Push/pop handshake bundle of ita_sync_fifo; master is the surrounding logic, slave is the FIFO.
interface ita_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
);

    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  push_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  pop_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  full_o;
    logic                  empty_o;
    logic [ADDR_DEPTH-1:0] usage_o;

    modport master (
        output push_i, data_i, pop_i,
        input  data_o, full_o, empty_o, usage_o
    );

    modport slave (
        input  push_i, data_i, pop_i,
        output data_o, full_o, empty_o, usage_o
    );

endinterface

// File: rtl/ita_sync_fifo.sv
// Single-clock FIFO with optional first-word fall-through and non-power-of-two depth support.
// Define ITA_FIFO_ASSERT_EN to compile in simulation-only usage checks.
module ita_sync_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           testmode_i,
    ita_sync_fifo_if.slave fifo_if
);

    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
    logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic empty;
    logic bypass;
    logic push_ok;
    logic pop_ok;
    logic write_en;
    logic unused_testmode;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign unused_testmode = testmode_i;

    // Fall-through only kicks in while the queue itself is empty.
    assign bypass = FALL_THROUGH && (status_cnt_q == '0) && fifo_if.push_i;
    assign full   = (status_cnt_q == FULL_CNT);
    assign empty  = (status_cnt_q == '0) && !bypass;

    assign fifo_if.full_o  = full;
    assign fifo_if.empty_o = empty;
    assign fifo_if.usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign fifo_if.data_o  = bypass ? fifo_if.data_i : mem_q[read_ptr_q];

    always_comb begin
        push_ok      = fifo_if.push_i && !full;
        pop_ok       = fifo_if.pop_i && !empty;
        read_ptr_d   = read_ptr_q;
        write_ptr_d  = write_ptr_q;
        status_cnt_d = status_cnt_q;

        // A word pushed and popped while empty never touches storage.
        if (bypass && fifo_if.pop_i) begin
            push_ok = 1'b0;
            pop_ok  = 1'b0;
        end

        if (push_ok) begin
            write_ptr_d = next_ptr(write_ptr_q);
        end
        if (pop_ok) begin
            read_ptr_d = next_ptr(read_ptr_q);
        end
        status_cnt_d = status_cnt_q + (ADDR_DEPTH+1)'(push_ok) - (ADDR_DEPTH+1)'(pop_ok);

        if (flush_i) begin
            read_ptr_d   = '0;
            write_ptr_d  = '0;
            status_cnt_d = '0;
        end

        write_en = push_ok && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
            if (write_en) begin
                mem_q[write_ptr_q] <= fifo_if.data_i;
            end
        end
    end

`ifdef ITA_FIFO_ASSERT_EN
    if (DEPTH < 1) begin : g_bad_depth
        $error("ita_sync_fifo: DEPTH must be at least 1");
    end

    always @(posedge clk_i) begin
        if (rst_ni && fifo_if.push_i && full) begin
            $error("ita_sync_fifo: push while full, data dropped");
        end
        if (rst_ni && fifo_if.pop_i && empty) begin
            $error("ita_sync_fifo: pop while empty ignored");
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) status_cnt_q <= FULL_CNT)
        else $error("ita_sync_fifo: status count exceeds DEPTH");
`else
    // Checks are compiled out; the datapath above is the complete design.
`endif

endmodule

// File: tb/tb_ita_sync_fifo.sv
// Self-checking bench for ita_sync_fifo: directed scenarios plus randomized runs against queue models.
// Three instances cover DEPTH=4 (ITA width), DEPTH=3 wrap and DEPTH=4 fall-through.
module tb_ita_sync_fifo;
    import ita_package::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flushA = 1'b0;
    logic flushB = 1'b0;
    logic flushC = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ita_sync_fifo_if #(.DATA_WIDTH($bits(fifo_data_t)), .DEPTH(FifoDepth)) ifA ();
    ita_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(3)) ifB ();
    ita_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(4)) ifC ();

    ita_sync_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH($bits(fifo_data_t)), .DEPTH(FifoDepth)) dutA (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flushA), .testmode_i(1'b0), .fifo_if(ifA)
    );
    ita_sync_fifo #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) dutB (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flushB), .testmode_i(1'b0), .fifo_if(ifB)
    );
    ita_sync_fifo #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) dutC (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flushC), .testmode_i(1'b1), .fifo_if(ifC)
    );

    task automatic test_reset();
        ifA.push_i = 0; ifA.pop_i = 0; ifA.data_i = '0;
        ifB.push_i = 0; ifB.pop_i = 0; ifB.data_i = '0;
        ifC.push_i = 0; ifC.pop_i = 0; ifC.data_i = '0;
        rst_n = 1'b0;
        #3;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_A: got %b expected 1", ifA.empty_o); end
        checks++; if (ifA.full_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_full_A: got %b expected 0", ifA.full_o); end
        checks++; if (ifA.usage_o !== 2'd0) begin errors++; $display("[TB] FAIL reset_usage_A: got %0d expected 0", ifA.usage_o); end
        checks++; if (ifA.data_o !== '0) begin errors++; $display("[TB] FAIL reset_data_A: got %0h expected 0", ifA.data_o); end
        checks++; if (ifB.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_B: got %b expected 1", ifB.empty_o); end
        checks++; if (ifC.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty_C: got %b expected 1", ifC.empty_o); end
        checks++; if (ifC.data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_C: got %0h expected 0", ifC.data_o); end
        #9;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_and_full();
        for (int i = 0; i < 4; i++) begin
            ifA.push_i = 1'b1;
            ifA.data_i = fifo_data_t'(4'hA + i);
            @(posedge clk); #1;
            checks++; if (ifA.usage_o !== 2'(i + 1)) begin errors++; $display("[TB] FAIL fill_usage[%0d]: got %0d expected %0d", i, ifA.usage_o, 2'(i + 1)); end
            checks++; if (ifA.full_o !== (i == 3)) begin errors++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, ifA.full_o, (i == 3)); end
            checks++; if (ifA.data_o !== fifo_data_t'(4'hA)) begin errors++; $display("[TB] FAIL fill_head[%0d]: got %0h expected a", i, ifA.data_o); end
        end
        ifA.push_i = 1'b0;
    endtask

    task automatic test_push_when_full();
        ifA.push_i = 1'b1;
        ifA.data_i = fifo_data_t'(8'h0E);
        @(posedge clk); #1;
        ifA.push_i = 1'b0;
        checks++; if (ifA.full_o !== 1'b1) begin errors++; $display("[TB] FAIL drop_full: got %b expected 1", ifA.full_o); end
        checks++; if (ifA.usage_o !== 2'd0) begin errors++; $display("[TB] FAIL drop_usage: got %0d expected 0", ifA.usage_o); end
        for (int i = 0; i < 4; i++) begin
            ifA.pop_i = 1'b1;
            #1;
            checks++; if (ifA.data_o !== fifo_data_t'(4'hA + i)) begin errors++; $display("[TB] FAIL drain_data[%0d]: got %0h expected %0h", i, ifA.data_o, 4'hA + i); end
            @(posedge clk); #1;
        end
        ifA.pop_i = 1'b0;
        #1;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", ifA.empty_o); end
        checks++; if (ifA.full_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_full: got %b expected 0", ifA.full_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 2; i++) begin
            ifA.push_i = 1'b1; ifA.data_i = fifo_data_t'(i);
            @(posedge clk); #1;
        end
        ifA.data_i = fifo_data_t'(5); ifA.pop_i = 1'b1;
        #1;
        checks++; if (ifA.data_o !== fifo_data_t'(1)) begin errors++; $display("[TB] FAIL b2b_head_pre: got %0h expected 1", ifA.data_o); end
        @(posedge clk); #1;
        ifA.push_i = 1'b0;
        checks++; if (ifA.usage_o !== 2'd2) begin errors++; $display("[TB] FAIL b2b_usage: got %0d expected 2", ifA.usage_o); end
        checks++; if (ifA.data_o !== fifo_data_t'(2)) begin errors++; $display("[TB] FAIL b2b_head_post: got %0h expected 2", ifA.data_o); end
        @(posedge clk); #1;
        checks++; if (ifA.data_o !== fifo_data_t'(5)) begin errors++; $display("[TB] FAIL b2b_last: got %0h expected 5", ifA.data_o); end
        @(posedge clk); #1;
        ifA.pop_i = 1'b0;
        #1;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 1", ifA.empty_o); end

        for (int i = 0; i < 4; i++) begin
            ifA.push_i = 1'b1; ifA.data_i = fifo_data_t'(8'h10 + i);
            @(posedge clk); #1;
        end
        ifA.data_i = fifo_data_t'(8'h99); ifA.pop_i = 1'b1;
        @(posedge clk); #1;
        ifA.push_i = 1'b0; ifA.pop_i = 1'b0;
        #1;
        checks++; if (ifA.usage_o !== 2'd3) begin errors++; $display("[TB] FAIL fullpop_usage: got %0d expected 3", ifA.usage_o); end
        checks++; if (ifA.full_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_full: got %b expected 0", ifA.full_o); end
        for (int i = 1; i < 4; i++) begin
            ifA.pop_i = 1'b1;
            #1;
            checks++; if (ifA.data_o !== fifo_data_t'(8'h10 + i)) begin errors++; $display("[TB] FAIL fullpop_data[%0d]: got %0h expected %0h", i, ifA.data_o, 8'h10 + i); end
            @(posedge clk); #1;
        end
        ifA.pop_i = 1'b0;
        #1;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_empty: got %b expected 1", ifA.empty_o); end
    endtask

    task automatic test_pointer_wrap();
        ifB.push_i = 1'b1; ifB.data_i = 8'd0;
        @(posedge clk); #1;
        for (int i = 1; i < 10; i++) begin
            ifB.data_i = 8'(i); ifB.pop_i = 1'b1;
            #1;
            checks++; if (ifB.data_o !== 8'(i - 1)) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %0d expected %0d", i, ifB.data_o, i - 1); end
            @(posedge clk); #1;
            checks++; if (ifB.usage_o !== 2'd1) begin errors++; $display("[TB] FAIL wrap_usage[%0d]: got %0d expected 1", i, ifB.usage_o); end
        end
        ifB.push_i = 1'b0;
        #1;
        checks++; if (ifB.data_o !== 8'd9) begin errors++; $display("[TB] FAIL wrap_last: got %0d expected 9", ifB.data_o); end
        @(posedge clk); #1;
        ifB.pop_i = 1'b0;
        #1;
        checks++; if (ifB.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL wrap_empty: got %b expected 1", ifB.empty_o); end
    endtask

    task automatic test_fall_through();
        ifC.push_i = 1'b1; ifC.pop_i = 1'b1; ifC.data_i = 8'h77;
        #1;
        checks++; if (ifC.data_o !== 8'h77) begin errors++; $display("[TB] FAIL ft_pass_data: got %0h expected 77", ifC.data_o); end
        checks++; if (ifC.empty_o !== 1'b0) begin errors++; $display("[TB] FAIL ft_pass_empty: got %b expected 0", ifC.empty_o); end
        @(posedge clk); #1;
        ifC.push_i = 1'b0; ifC.pop_i = 1'b0;
        #1;
        checks++; if (ifC.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL ft_after_empty: got %b expected 1", ifC.empty_o); end
        checks++; if (ifC.usage_o !== 2'd0) begin errors++; $display("[TB] FAIL ft_after_usage: got %0d expected 0", ifC.usage_o); end
        ifC.push_i = 1'b1;
        #1;
        checks++; if (ifC.data_o !== 8'h77) begin errors++; $display("[TB] FAIL ft_write_comb: got %0h expected 77", ifC.data_o); end
        @(posedge clk); #1;
        ifC.push_i = 1'b0;
        #1;
        checks++; if (ifC.usage_o !== 2'd1) begin errors++; $display("[TB] FAIL ft_write_usage: got %0d expected 1", ifC.usage_o); end
        checks++; if (ifC.data_o !== 8'h77) begin errors++; $display("[TB] FAIL ft_write_data: got %0h expected 77", ifC.data_o); end
        ifC.pop_i = 1'b1;
        @(posedge clk); #1;
        ifC.pop_i = 1'b0;
        #1;
        checks++; if (ifC.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL ft_drain_empty: got %b expected 1", ifC.empty_o); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            ifA.push_i = 1'b1; ifA.data_i = fifo_data_t'(8'h21 + i);
            @(posedge clk); #1;
        end
        ifA.data_i = fifo_data_t'(8'h99); flushA = 1'b1;
        @(posedge clk); #1;
        ifA.push_i = 1'b0; flushA = 1'b0;
        #1;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %b expected 1", ifA.empty_o); end
        checks++; if (ifA.usage_o !== 2'd0) begin errors++; $display("[TB] FAIL flush_usage: got %0d expected 0", ifA.usage_o); end
        ifA.push_i = 1'b1; ifA.data_i = fifo_data_t'(8'h42);
        @(posedge clk); #1;
        ifA.push_i = 1'b0;
        checks++; if (ifA.data_o !== fifo_data_t'(8'h42)) begin errors++; $display("[TB] FAIL flush_repush: got %0h expected 42", ifA.data_o); end
        checks++; if (ifA.usage_o !== 2'd1) begin errors++; $display("[TB] FAIL flush_repush_usage: got %0d expected 1", ifA.usage_o); end
    endtask

    task automatic test_async_reset();
        ifA.push_i = 1'b1; ifA.data_i = fifo_data_t'(8'h55);
        @(posedge clk); #1;
        ifA.push_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ifA.empty_o !== 1'b1) begin errors++; $display("[TB] FAIL arst_empty: got %b expected 1", ifA.empty_o); end
        checks++; if (ifA.usage_o !== 2'd0) begin errors++; $display("[TB] FAIL arst_usage: got %0d expected 0", ifA.usage_o); end
        checks++; if (ifA.data_o !== '0) begin errors++; $display("[TB] FAIL arst_data: got %0h expected 0", ifA.data_o); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random_a();
        fifo_data_t model[$];
        fifo_data_t d;
        logic p, po, fl;
        for (int n = 0; n < 400; n++) begin
            p  = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 19) == 0);
            d  = {$urandom, $urandom, $urandom, $urandom};
            ifA.push_i = p; ifA.pop_i = po; ifA.data_i = d; flushA = fl;
            #1;
            checks++; if (ifA.empty_o !== (model.size() == 0)) begin errors++; $display("[TB] FAIL randA_empty[%0d]: got %b expected %b", n, ifA.empty_o, model.size() == 0); end
            checks++; if (ifA.full_o !== (model.size() == FifoDepth)) begin errors++; $display("[TB] FAIL randA_full[%0d]: got %b expected %b", n, ifA.full_o, model.size() == FifoDepth); end
            checks++; if (ifA.usage_o !== fifo_usage_t'(model.size())) begin errors++; $display("[TB] FAIL randA_usage[%0d]: got %0d expected %0d", n, ifA.usage_o, fifo_usage_t'(model.size())); end
            if (model.size() > 0) begin
                checks++; if (ifA.data_o !== model[0]) begin errors++; $display("[TB] FAIL randA_data[%0d]: got %0h expected %0h", n, ifA.data_o, model[0]); end
            end
            @(posedge clk);
            if (fl) begin
                model.delete();
            end else begin
                automatic bit can_push = p && (model.size() < FifoDepth);
                if (po && model.size() > 0) void'(model.pop_front());
                if (can_push) model.push_back(d);
            end
            #1;
        end
        ifA.push_i = 1'b0; ifA.pop_i = 1'b0; flushA = 1'b0;
    endtask

    task automatic test_random_c();
        logic [7:0] model[$];
        logic [7:0] d;
        logic p, po, fl;
        logic exp_empty;
        for (int n = 0; n < 400; n++) begin
            p  = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 19) == 0);
            d  = 8'($urandom);
            ifC.push_i = p; ifC.pop_i = po; ifC.data_i = d; flushC = fl;
            #1;
            exp_empty = (model.size() == 0) && !p;
            checks++; if (ifC.empty_o !== exp_empty) begin errors++; $display("[TB] FAIL randC_empty[%0d]: got %b expected %b", n, ifC.empty_o, exp_empty); end
            checks++; if (ifC.full_o !== (model.size() == 4)) begin errors++; $display("[TB] FAIL randC_full[%0d]: got %b expected %b", n, ifC.full_o, model.size() == 4); end
            checks++; if (ifC.usage_o !== 2'(model.size())) begin errors++; $display("[TB] FAIL randC_usage[%0d]: got %0d expected %0d", n, ifC.usage_o, 2'(model.size())); end
            if (!exp_empty) begin
                automatic logic [7:0] exp_data = (model.size() == 0) ? d : model[0];
                checks++; if (ifC.data_o !== exp_data) begin errors++; $display("[TB] FAIL randC_data[%0d]: got %0h expected %0h", n, ifC.data_o, exp_data); end
            end
            @(posedge clk);
            if (fl) begin
                model.delete();
            end else if (!(model.size() == 0 && p && po)) begin
                automatic bit can_push = p && (model.size() < 4);
                if (po && model.size() > 0) void'(model.pop_front());
                if (can_push) model.push_back(d);
            end
            #1;
        end
        ifC.push_i = 1'b0; ifC.pop_i = 1'b0; flushC = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_and_full();
        test_push_when_full();
        test_back_to_back();
        test_pointer_wrap();
        test_fall_through();
        test_flush();
        test_async_reset();
        test_random_a();
        test_random_c();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ita_sync_fifo.md
Name: ita_sync_fifo

Overview:
- Synchronous single-clock FIFO with parameterizable width and depth.
- Optional fall-through (first-word bypass) mode.
- In ITA it buffers requantized output rows (DATA_WIDTH = N*WI, DEPTH = FifoDepth) between the FIFO controller (push side) and the output controller (pop side).
- Reports full, empty and fill level.

Parameters:
- FALL_THROUGH, 1'b0: 1 = when empty, pushed data is visible on data_o in the same cycle.
- DATA_WIDTH, 32: word width in bits.
- DEPTH, 8: number of entries; must be >= 1.
- ADDR_DEPTH (derived, not overridable): DEPTH > 1 ? $clog2(DEPTH) : 1.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all contents.
- testmode_i  in  1  DFT bypass; no functional effect.
- full_o  out  1  FIFO holds DEPTH entries.
- empty_o  out  1  no data available.
- usage_o  out  ADDR_DEPTH  current entry count (low ADDR_DEPTH bits).
- data_i  in  DATA_WIDTH  write data.
- push_i  in  1  write request.
- data_o  out  DATA_WIDTH  head-of-queue data.
- pop_i  in  1  read request.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports clk_i / rst_ni.
- State: storage array of DEPTH x DATA_WIDTH, read_ptr and write_ptr (ADDR_DEPTH bits), status_cnt (ADDR_DEPTH+1 bits).
- Reset: pointers, count and storage all cleared to 0. After reset: empty_o=1, full_o=0, usage_o=0, data_o=0.
- full_o = (status_cnt == DEPTH), combinational from registers.
- empty_o = (status_cnt == 0) and not (FALL_THROUGH and push_i).
- usage_o = status_cnt[ADDR_DEPTH-1:0]. For power-of-two DEPTH this wraps to 0 when full; consumers must qualify with full_o.
- Push:
  - When push_i and not full_o: write data_i at write_ptr, increment write_ptr, count +1.
  - Push while full is dropped silently; no state change.
- Pop:
  - When pop_i and not empty_o: increment read_ptr, count -1.
  - Pop while empty is ignored.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0, so non-power-of-two depths are supported.
- Simultaneous push and pop (both legal): both pointers advance and the count is unchanged.
- Push when full with pop in the same cycle: the push is still dropped, because full_o is evaluated before the pop.
- data_o:
  - Normally storage[read_ptr], a registered-read view.
  - Valid whenever empty_o=0.
  - New data is visible on data_o one cycle after the push.
- Fall-through (FALL_THROUGH=1) with status_cnt==0 and push_i:
  - data_o = data_i combinationally and empty_o=0.
  - If pop_i is also high: the word passes straight through. No write occurs and pointers and count do not change.
  - If pop_i is low: a normal write occurs.
- flush_i:
  - Next edge clears read_ptr, write_ptr and count; storage contents are not cleared.
  - Overrides push and pop in the same cycle.
- Asynchronous reset mid-operation: immediate return to the reset state, with all data discarded.
- Latency: 1 cycle push-to-visible (0 in fall-through when empty). Pop takes effect at the next edge.

Optional Feature:
- Macro ITA_FIFO_ASSERT_EN. When defined, the following simulation-only checks are compiled in:
  - Elaboration error if DEPTH < 1.
  - Error message on push_i while full_o.
  - Error message on pop_i while empty_o.
  - Assertion that status_cnt never exceeds DEPTH.
- When undefined: no checks, and synthesis is identical.

Decomposition:
- Shared package (ita_package) holds:
  - fifo_data_t (logic [N*WI-1:0]).
  - fifo_usage_t (logic [$clog2(FifoDepth)-1:0]).
  - FifoDepth constant.
- The FIFO itself stays generic (parameters only) and does not import the package.
- No sub-module: storage array, pointers and counter live inline in one module.

Test Plan:
- Reset, DEPTH=4, FALL_THROUGH=0: after reset empty_o=1, full_o=0, usage_o=0. Push 0xA,0xB,0xC,0xD on consecutive cycles -> usage_o goes 1,2,3, then full_o=1 with usage_o=0 (wrap).
- Push while full: push 0xE with DEPTH=4 full -> ignored. Pops return A,B,C,D in order, then empty_o=1.
- Simultaneous push and pop at count 2: push 0x5, pop -> usage_o stays 2, head advances, 0x5 is later returned last.
- Pointer wrap, DEPTH=3: 10 push/pop pairs with values 0..9 -> outputs in order, no loss.
- Fall-through, FALL_THROUGH=1, empty:
  - Push 0x77 with pop same cycle -> data_o=0x77 that cycle, empty_o=0; next cycle empty_o=1, usage_o=0.
  - Push without pop -> data_o=0x77, usage_o=1 next cycle.
- Flush and async reset: flush with 3 entries plus a simultaneous push -> next cycle empty_o=1, usage_o=0. Assert rst_ni low mid-stream -> outputs return to the reset values immediately.
